// File: rtl/alu_op_sequencer.sv
// Serial operand fetcher / result writer driving an external 32-bit combinational ALU.
// Reads A and B from a 32-entry synchronous memory, executes, writes R back to rd.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_ra,
    input  logic [4:0]  cmd_rb,
    input  logic [4:0]  cmd_rd,
    output logic [4:0]  mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_r,
    output logic        done,
    output logic        err,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_LD_B = 3'd3,
        S_EXEC = 3'd4,
        S_WR   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rb_q, rb_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  mem_addr_q, mem_addr_d;
    logic        mem_rd_en_q, mem_rd_en_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_sel_q, alu_sel_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;

    logic accept;
    logic op_legal;

    // cmd_ready_q is low for the first cycle after reset, which blocks acceptance there.
    assign accept   = cmd_valid && cmd_ready_q;
    assign op_legal = (cmd_op < 3'd6);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && op_legal) state_d = S_RD_A;
            S_RD_A: state_d = S_RD_B;
            S_RD_B: state_d = S_LD_B;
            S_LD_B: state_d = S_EXEC;
            S_EXEC: state_d = S_WR;
            S_WR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is a flop, so each one is loaded with the value for the state being entered.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        op_d        = op_q;
        rb_d        = rb_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        result_d    = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = cmd_op;
                    rb_d = cmd_rb;
                    rd_d = cmd_rd;
                    if (op_legal) begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = cmd_ra;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_RD_A: begin
                mem_rd_en_d = 1'b1;
                mem_addr_d  = rb_q;
            end
            S_RD_B: alu_a_d = mem_rdata;
            S_LD_B: begin
                alu_b_d   = mem_rdata;
                alu_sel_d = op_q;
            end
            S_EXEC: begin
                result_d    = alu_r;
                mem_wdata_d = alu_r;
                mem_wr_en_d = 1'b1;
                mem_addr_d  = rd_q;
            end
            S_WR: done_d = 1'b1;
            default: ;
        endcase
    end

    // Async clear drops mem_wr_en at once, so a reset landing in WR never reaches the memory edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            op_q        <= 3'd0;
            rb_q        <= 5'd0;
            rd_q        <= 5'd0;
            mem_addr_q  <= 5'd0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= 32'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            alu_sel_q   <= 3'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            op_q        <= op_d;
            rb_q        <= rb_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_wdata_q <= mem_wdata_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural memory + ALU, reference model on a shadow memory,
// directed scenarios followed by random commands.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_ra, cmd_rb, cmd_rd;
    logic [4:0]  mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_r;
    logic        done, err;
    logic [31:0] result;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r),
        .done(done), .err(err), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return (a < b) ? 32'd1 : 32'd0;
            3'd5: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_r = alu_fn(alu_sel, alu_a, alu_b);

    // Behavioural memory with access logging
    logic [31:0] mem [32];
    logic [31:0] exp_mem [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = 5'd0;
    logic [31:0] pre_data = 32'd0;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [4:0]  rd_hist [256];
    logic [4:0]  wr_hist [256];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            rd_hist[rd_cnt & 255] <= mem_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (mem_wr_en) begin
            wr_hist[wr_cnt & 255] <= mem_addr;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    end

    int          checks = 0, failures = 0;
    logic [31:0] exp_res = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
        chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_addr"}, {27'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_sel"}, {29'd0, alu_sel}, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        exp_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Returns just after the accept edge T.
    task automatic issue(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("issue_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_ra = 5'($urandom); cmd_rb = 5'($urandom); cmd_rd = 5'($urandom);
    endtask

    task automatic wait_done(output int lat, output int drops, output logic e);
        lat = -1; drops = 0; e = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!cmd_ready) drops++;
            if (done) begin
                lat = k; e = err;
                break;
            end
        end
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
        int lat, drops, r0, w0;
        logic e, legal;
        logic [31:0] r;
        legal = (op <= 3'd5);
        r = alu_fn(op, exp_mem[ra], exp_mem[rb]);
        r0 = rd_cnt; w0 = wr_cnt;
        issue(op, ra, rb, rd);
        wait_done(lat, drops, e);
        if (legal) begin
            exp_mem[rd] = r;
            exp_res = r;
        end
        chk({tag, "_latency"}, 32'(lat), legal ? 32'd6 : 32'd1);
        chk({tag, "_err"}, {31'd0, e}, legal ? 32'd0 : 32'd1);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_mem_rd"}, mem[rd], exp_mem[rd]);
        chk({tag, "_nreads"}, 32'(rd_cnt - r0), legal ? 32'd2 : 32'd0);
        chk({tag, "_nwrites"}, 32'(wr_cnt - w0), legal ? 32'd1 : 32'd0);
        if (legal) begin
            chk({tag, "_rd_addr_a"}, {27'd0, rd_hist[r0 & 255]}, {27'd0, ra});
            chk({tag, "_rd_addr_b"}, {27'd0, rd_hist[(r0 + 1) & 255]}, {27'd0, rb});
            chk({tag, "_wr_addr"}, {27'd0, wr_hist[w0 & 255]}, {27'd0, rd});
        end else begin
            chk({tag, "_ready_drops"}, 32'(drops), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic reset_abort(input string tag, input int at_cycle);
        int w0, dn;
        w0 = wr_cnt; dn = 0;
        issue(3'd5, 5'd1, 5'd2, 5'd9);
        for (int k = 1; k <= at_cycle; k++) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_outs({tag, "_rst"});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        exp_res = 32'd0;
        #1 chk({tag, "_ready_pre_edge"}, {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        if (done) dn++;
        chk({tag, "_ready_post_edge"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_no_done"}, 32'(dn), 32'd0);
        chk({tag, "_mem9"}, mem[9], 32'h1234);
        chk({tag, "_nwrites"}, 32'(wr_cnt - w0), 32'd0);
    endtask

    initial begin
        int lat, drops, r0, k2;
        logic e;
        cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("por");
        rst_n = 1'b1;
        #1 chk("por_ready_pre_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("por_ready_post_edge", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 32; i++) preload(5'(i), $urandom);

        preload(5'd1, 32'd5); preload(5'd2, 32'd3);
        run_cmd("add", 3'd2, 5'd1, 5'd2, 5'd3);
        chk("add_const", mem[3], 32'd8);

        preload(5'd1, 32'd3); preload(5'd2, 32'd5);
        run_cmd("subs", 3'd3, 5'd1, 5'd2, 5'd4);
        chk("subs_const", mem[4], 32'hFFFF_FFFE);

        preload(5'd5, 32'hFFFF_FFFF); preload(5'd6, 32'd1);
        run_cmd("solt", 3'd4, 5'd5, 5'd6, 5'd7);
        chk("solt_const", mem[7], 32'd0);

        run_cmd("illegal6", 3'd6, 5'd1, 5'd2, 5'd3);
        run_cmd("illegal7", 3'd7, 5'd4, 5'd5, 5'd6);

        // Back-to-back: second command held valid from the cycle after the first accept
        preload(5'd1, 32'd5); preload(5'd2, 32'd3);
        r0 = rd_cnt;
        issue(3'd2, 5'd1, 5'd2, 5'd1);
        exp_mem[1] = 32'd8;
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_ra = 5'd1; cmd_rb = 5'd1; cmd_rd = 5'd0;
        k2 = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                k2 = k;
                break;
            end
        end
        chk("b2b_ready_cycle", 32'(k2), 32'd6);
        chk("b2b_first_done", {31'd0, done}, 32'd1);
        chk("b2b_busy_reads", 32'(rd_cnt - r0), 32'd2);
        chk("b2b_mem1", mem[1], 32'd8);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(lat, drops, e);
        exp_mem[0] = alu_fn(3'd0, exp_mem[1], exp_mem[1]);
        exp_res = exp_mem[0];
        chk("b2b_second_latency", 32'(lat), 32'd6);
        chk("b2b_mem0", mem[0], 32'd8);
        chk("b2b_rd_a", {27'd0, rd_hist[(r0 + 2) & 255]}, 32'd1);
        chk("b2b_rd_b", {27'd0, rd_hist[(r0 + 3) & 255]}, 32'd1);

        preload(5'd1, 32'd0); preload(5'd2, 32'd0); preload(5'd9, 32'h1234);
        reset_abort("rst_exec", 4);
        reset_abort("rst_wr", 5);

        preload(5'd10, 32'd7);
        run_cmd("same_addr", 3'd1, 5'd10, 5'd10, 5'd10);
        chk("same_addr_const", mem[10], 32'd7);
        chk("same_addr_res", result, 32'd7);

        for (int i = 0; i < 40; i++)
            run_cmd("rand", 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom));

        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], exp_mem[i]);
        chk("rd_wr_overlap", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential operand fetcher and result writer that drives the team's 32-bit combinational ALU from a 32-entry data memory. It accepts one command (opcode plus three memory addresses), reads operands A and B, presents them to the ALU, captures R and writes it back. It sits between the command source (testbench or future control unit) and the memory/ALU pair, acting as the initiator side of the ALU operand/result interface.

## Interface

- No parameters. Data width is fixed at 32 bits and address width at 5 bits.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer idle and able to accept a command.
- `cmd_op` input 3: operation. 0=AND, 1=OR, 2=ADD, 3=SUBS, 4=SOLT, 5=NOR; 6 and 7 are illegal.
- `cmd_ra` input 5: address of operand A.
- `cmd_rb` input 5: address of operand B.
- `cmd_rd` input 5: destination address.
- `mem_addr` output 5: memory address.
- `mem_rd_en` output 1: synchronous read request. `mem_rdata` is valid in the following cycle.
- `mem_rdata` input 32: memory read data.
- `mem_wr_en` output 1: write strobe, applied at the clock edge.
- `mem_wdata` output 32: write data.
- `alu_a` output 32: ALU operand A.
- `alu_b` output 32: ALU operand B.
- `alu_sel` output 3: opcode forwarded to the ALU mux, same encoding as `cmd_op`.
- `alu_r` input 32: combinational ALU result.
- `done` output 1: one-cycle pulse when a command completes.
- `err` output 1: qualifies `done`; high when the command was rejected as illegal.
- `result` output 32: last written result. Holds its value until the next EXEC.

## Operation

- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. While busy, `cmd_ready` is 0 and `cmd_valid` is ignored. Command fields are latched at acceptance, so the source may change them afterwards.
- FSM states: IDLE, RD_A, RD_B, LD_B, EXEC, WR.
  - IDLE: on accept with legal op, go to RD_A. On accept with illegal op, stay in IDLE and pulse `done` and `err` in the next cycle. An illegal op causes no memory access.
  - RD_A: `mem_rd_en`=1, `mem_addr`=ra. Next state RD_B.
  - RD_B: capture `mem_rdata` into operand A register. `mem_rd_en`=1, `mem_addr`=rb. Next state LD_B.
  - LD_B: capture `mem_rdata` into operand B register. Next state EXEC.
  - EXEC: `alu_a`/`alu_b` come from the operand registers and `alu_sel` from the latched op. Capture `alu_r` into `result`. Next state WR.
  - WR: `mem_wr_en`=1, `mem_addr`=rd, `mem_wdata`=`result`. Next state IDLE. `done`=1 (with `err`=0) in the following cycle.
- `mem_rd_en` and `mem_wr_en` are never high together.
- Outside RD_A, RD_B and WR, `mem_addr` holds its last value.
- Arithmetic is performed entirely by the external ALU. The sequencer does not alter `alu_r`:
  - ADD/SUBS wrap modulo 2^32.
  - SOLT is an unsigned compare that returns 0 or 1.
- ra, rb and rd may be equal. Because the sequencer is strictly serial, a later command always reads values written by earlier ones.
- All outputs are registered.

## Timing

- Accept edge is T (end of IDLE cycle).
- Cycle by cycle: RD_A=T+1, RD_B=T+2, LD_B=T+3, EXEC=T+4, WR=T+5 (write at the end of T+5).
- In cycle T+6: `done`=1 and `cmd_ready`=1. A new command may be accepted at the end of T+6, giving 6 cycles accept-to-accept.
- Illegal op: `done`=`err`=1 in T+1 with `cmd_ready`=1 throughout.
- Reset values:
  - `cmd_ready`=0; it goes to 1 at the first `clk` edge after `rst_n` rises.
  - `mem_rd_en`=0, `mem_wr_en`=0, `done`=0, `err`=0.
  - `mem_addr`, `mem_wdata`, `alu_a`, `alu_b`, `result` = 0; `alu_sel`=0.
  - State = IDLE.
- Reset mid-operation aborts immediately. No write is issued after `rst_n` falls, even if reset lands in WR before the edge, and no `done` pulse is produced for the aborted command.

## Test plan

- Preload mem[1]=5, mem[2]=3; send op=2 (ADD), ra=1, rb=2, rd=3. Expect:
  - `done` at T+6 with `err`=0.
  - `result`=8 and mem[3]=8.
  - Exactly two reads (addresses 1 then 2) and one write (address 3).
- SUBS: mem[1]=3, mem[2]=5, rd=4. Expect mem[4]=0xFFFFFFFE. SOLT: mem[5]=0xFFFFFFFF, mem[6]=1, rd=7. Expect mem[7]=0 (unsigned).
- Send op=6. Expect `done`=`err`=1 at T+1, no `mem_rd_en`/`mem_wr_en` activity, and `cmd_ready` never dropping.
- Back-to-back: ADD rd=1 from mem[1]=5, mem[2]=3, then AND ra=1, rb=1, rd=0 held valid. Expect:
  - Second accept at T+6.
  - mem[0]=8.
  - `cmd_valid` is ignored while busy.
- Assert `rst_n`=0 during EXEC of NOR with mem[1]=0, mem[2]=0, rd=9 (mem[9] preset to 0x1234). Expect:
  - mem[9] still 0x1234 and no `done`.
  - All outputs at reset values.
  - `cmd_ready`=1 one edge after release.
- Same address for all fields (ra=rb=rd=10, mem[10]=7, OR). Expect mem[10]=7 and `result`=7.
